time_set_controller: RTL and testbench

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/time_set_controller.sv | 195 +++++++++++++++++++
 tb/tb_time_set_controller.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Field-selection and increment controller for a clock set mode.
// Two debounced active-low keys drive a NONE/S1..S6 FSM with auto-repeat, timeout and blink.
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_HALF      = 25000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned TIMEOUT_TICKS   = 30
) (
  input  logic       inputClock,
  input  logic       nReset,
  input  logic       selectKey,
  input  logic       advanceKey,
  input  logic       tick1Hz,
  input  logic       pauseSwitch,
  output logic [3:0] selected,
  output logic [5:0] incPulse,
  output logic       runEnable,
  output logic [5:0] blankMask
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned ArmW  = $clog2(DEBOUNCE_CYCLES + 3);
  localparam int unsigned BlW   = $clog2(BLINK_HALF + 1);
  localparam int unsigned RpMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RpW   = $clog2(RpMax + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ArmW-1:0] ArmLast = ArmW'(DEBOUNCE_CYCLES + 1);
  localparam logic [BlW-1:0]  BlLast  = BlW'(BLINK_HALF - 1);
  localparam logic [RpW-1:0]  DelLast = RpW'(REPEAT_DELAY - 1);
  localparam logic [RpW-1:0]  PerLast = RpW'(REPEAT_PERIOD - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {StNone, StS1, StS2, StS3, StS4, StS5, StS6} state_e;

  // Index 0 = select key, index 1 = advance key.
  logic [1:0]      raw_keys;
  logic [1:0]      sync1_q, sync2_q, acc_q, armed_q, press_q;
  logic [DbW-1:0]  db_cnt_q  [2];
  logic [ArmW-1:0] arm_cnt_q [2];

  state_e          state_q, state_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [RpW-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic            rpt_run_q, rpt_run_d;
  logic            rpt_per_q, rpt_per_d;
  logic [BlW-1:0]  bl_cnt_q, bl_cnt_d;
  logic            phase_q, phase_d;
  logic [5:0]      inc_q, inc_d;
  logic [5:0]      blank_q, blank_d;
  logic            run_q, run_d;

  logic            sel_ev, adv_ev, in_set, stay, entering, fire;
  logic [2:0]      idx_q, idx_d;

  assign raw_keys = {advanceKey, selectKey};

  // A key stays disarmed after reset until it has read released long enough, so a key
  // held across reset can never produce a press event.
  always_ff @(posedge inputClock) begin
    if (!nReset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      acc_q   <= 2'b11;
      armed_q <= 2'b00;
      press_q <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        db_cnt_q[k]  <= '0;
        arm_cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= raw_keys;
      sync2_q <= sync1_q;
      for (int k = 0; k < 2; k++) begin
        press_q[k] <= 1'b0;
        if (sync2_q[k] == acc_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DbLast) begin
          db_cnt_q[k] <= '0;
          acc_q[k]    <= sync2_q[k];
          press_q[k]  <= ~sync2_q[k] & armed_q[k];
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
        end
        if (!armed_q[k]) begin
          if (!sync2_q[k]) begin
            arm_cnt_q[k] <= '0;
          end else if (arm_cnt_q[k] == ArmLast) begin
            armed_q[k] <= 1'b1;
          end else begin
            arm_cnt_q[k] <= arm_cnt_q[k] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge inputClock) begin
    if (!nReset) begin
      state_q   <= StNone;
      to_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      rpt_run_q <= 1'b0;
      rpt_per_q <= 1'b0;
      bl_cnt_q  <= '0;
      phase_q   <= 1'b0;
      inc_q     <= '0;
      blank_q   <= '0;
      run_q     <= ~pauseSwitch;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      rpt_run_q <= rpt_run_d;
      rpt_per_q <= rpt_per_d;
      bl_cnt_q  <= bl_cnt_d;
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      blank_q   <= blank_d;
      run_q     <= run_d;
    end
  end

  always_comb begin
    sel_ev    = press_q[0];
    adv_ev    = press_q[1];
    in_set    = (state_q != StNone);
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    rpt_run_d = rpt_run_q;
    rpt_per_d = rpt_per_q;
    bl_cnt_d  = bl_cnt_q;
    phase_d   = phase_q;
    fire      = 1'b0;
    idx_q     = 3'(state_q) - 3'd1;

    if (sel_ev) begin
      state_d = (state_q == StS6) ? StNone : state_e'(3'(state_q) + 3'd1);
    end else if (in_set && !adv_ev && tick1Hz && (to_cnt_q == ToLast)) begin
      state_d = StNone;
    end

    stay     = (state_d == state_q);
    entering = (state_d != StNone) && !stay;
    idx_d    = 3'(state_d) - 3'd1;

    if (sel_ev || adv_ev || !in_set) begin
      to_cnt_d = '0;
    end else if (tick1Hz) begin
      to_cnt_d = (to_cnt_q == ToLast) ? '0 : to_cnt_q + 1'b1;
    end

    // Auto-repeat runs only from a genuine press in a set state; any state change stops it.
    if (adv_ev && !sel_ev && in_set && stay) begin
      fire      = 1'b1;
      rpt_run_d = 1'b1;
      rpt_per_d = 1'b0;
      rpt_cnt_d = '0;
    end else if (rpt_run_q) begin
      if (!stay || acc_q[1]) begin
        rpt_run_d = 1'b0;
        rpt_cnt_d = '0;
      end else if (rpt_cnt_q == (rpt_per_q ? PerLast : DelLast)) begin
        fire      = 1'b1;
        rpt_per_d = 1'b1;
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end

    if ((state_d == StNone) || entering || fire) begin
      bl_cnt_d = '0;
      phase_d  = 1'b0;
    end else if (bl_cnt_q == BlLast) begin
      bl_cnt_d = '0;
      phase_d  = ~phase_q;
    end else begin
      bl_cnt_d = bl_cnt_q + 1'b1;
    end

    inc_d   = fire ? (6'd1 << idx_q) : 6'd0;
    blank_d = (state_d == StNone) ? 6'd0 : ({5'd0, phase_d} << idx_d);
    run_d   = (state_d == StNone) && !pauseSwitch;
  end

  assign selected  = {1'b0, state_q};
  assign incPulse  = inc_q;
  assign runEnable = run_q;
  assign blankMask = blank_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Randomized self-checking bench for time_set_controller with small timing parameters.
// Expectations come from the key-hold lengths and the field/repeat rules, not from the RTL.
module tb_time_set_controller;

  localparam int unsigned DB = 4;
  localparam int unsigned BH = 8;
  localparam int unsigned RD = 16;
  localparam int unsigned RP = 4;
  localparam int unsigned TT = 3;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       selectKey = 1'b1;
  logic       advanceKey = 1'b1;
  logic       tick1Hz = 1'b0;
  logic       pauseSwitch = 1'b0;
  logic [3:0] selected;
  logic [5:0] incPulse;
  logic       runEnable;
  logic [5:0] blankMask;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sel_m = 0;
  int pulse_cyc[$];
  logic [5:0] pulse_val[$];

  time_set_controller #(
    .DEBOUNCE_CYCLES(DB),
    .BLINK_HALF(BH),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .TIMEOUT_TICKS(TT)
  ) dut (
    .inputClock(clk),
    .nReset(nReset),
    .selectKey(selectKey),
    .advanceKey(advanceKey),
    .tick1Hz(tick1Hz),
    .pauseSwitch(pauseSwitch),
    .selected(selected),
    .incPulse(incPulse),
    .runEnable(runEnable),
    .blankMask(blankMask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (incPulse !== 6'd0) begin
      pulse_cyc.push_back(cyc);
      pulse_val.push_back(incPulse);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] onehot(input int s);
    logic [5:0] v;
    v = 6'd1;
    v = v << (s - 1);
    return v;
  endfunction

  function automatic int expected_pulses(input int s, input int hold);
    if (s == 0 || hold < int'(DB)) return 0;
    if (hold < int'(RD) + 1) return 1;
    return 2 + (hold - int'(RD) - 1) / int'(RP);
  endfunction

  task automatic clear_pulses();
    pulse_cyc.delete();
    pulse_val.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    selectKey = 1'b1;
    advanceKey = 1'b1;
    nReset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;
    sel_m = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press(input bit adv, input int len);
    @(negedge clk);
    if (adv) advanceKey = 1'b0;
    else selectKey = 1'b0;
    repeat (len) @(negedge clk);
    if (adv) advanceKey = 1'b1;
    else selectKey = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  task automatic goto_field(input int target);
    while (sel_m != target) begin
      press(1'b0, 6);
      sel_m = (sel_m + 1) % 7;
    end
  endtask

  task automatic test_reset();
    pauseSwitch = 1'b1;
    @(negedge clk);
    nReset = 1'b0;
    @(negedge clk);
    if (selected !== 4'd0) begin
      failures++; $display("FAIL reset_selected: got %0d want 0", selected);
    end
    checks++;
    if (incPulse !== 6'd0) begin
      failures++; $display("FAIL reset_inc: got %b want 000000", incPulse);
    end
    checks++;
    if (blankMask !== 6'd0) begin
      failures++; $display("FAIL reset_blank: got %b want 000000", blankMask);
    end
    checks++;
    if (runEnable !== 1'b0) begin
      failures++; $display("FAIL reset_run_paused: got %b want 0", runEnable);
    end
    checks++;
    pauseSwitch = 1'b0;
    @(negedge clk);
    if (runEnable !== 1'b1) begin
      failures++; $display("FAIL reset_run: got %b want 1", runEnable);
    end
    checks++;
    nReset = 1'b1;
    sel_m = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_select_cycle();
    for (int i = 0; i < 7; i++) begin
      press(1'b0, 6);
      sel_m = (sel_m + 1) % 7;
      if (selected !== 4'(sel_m)) begin
        failures++; $display("FAIL select_step%0d: got %0d want %0d", i, selected, sel_m);
      end
      checks++;
      if (runEnable !== (sel_m == 0)) begin
        failures++; $display("FAIL select_run%0d: got %b want %b", i, runEnable, sel_m == 0);
      end
      checks++;
    end
    pauseSwitch = 1'b1;
    repeat (2) @(negedge clk);
    if (runEnable !== 1'b0) begin
      failures++; $display("FAIL pause_run: got %b want 0", runEnable);
    end
    checks++;
    pauseSwitch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_debounce();
    int len;
    press(1'b0, 3);
    if (selected !== 4'(sel_m)) begin
      failures++; $display("FAIL bounce3: got %0d want %0d", selected, sel_m);
    end
    checks++;
    press(1'b0, 10);
    sel_m = (sel_m + 1) % 7;
    if (selected !== 4'(sel_m)) begin
      failures++; $display("FAIL press10: got %0d want %0d", selected, sel_m);
    end
    checks++;
    for (int i = 0; i < 10; i++) begin
      len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(6, 12));
      press(1'b0, len);
      if (len >= int'(DB)) sel_m = (sel_m + 1) % 7;
      if (selected !== 4'(sel_m)) begin
        failures++; $display("FAIL debounce_rand len=%0d: got %0d want %0d", len, selected, sel_m);
      end
      checks++;
    end
  endtask

  task automatic check_repeat(input string name, input int hold);
    int n;
    n = expected_pulses(sel_m, hold);
    if (pulse_cyc.size() != n) begin
      failures++;
      $display("FAIL %s_count hold=%0d sel=%0d: got %0d want %0d", name, hold, sel_m,
               pulse_cyc.size(), n);
    end
    checks++;
    for (int i = 0; i < pulse_val.size(); i++) begin
      if (pulse_val[i] !== onehot(sel_m)) begin
        failures++; $display("FAIL %s_val%0d: got %b want %b", name, i, pulse_val[i], onehot(sel_m));
      end
      checks++;
      if (i > 0) begin
        if (pulse_cyc[i] - pulse_cyc[i-1] != ((i == 1) ? int'(RD) : int'(RP))) begin
          failures++;
          $display("FAIL %s_gap%0d: got %0d want %0d", name, i, pulse_cyc[i] - pulse_cyc[i-1],
                   (i == 1) ? RD : RP);
        end
        checks++;
      end
    end
  endtask

  task automatic test_auto_repeat();
    goto_field(3);
    clear_pulses();
    press(1'b1, 40);
    check_repeat("repeat40", 40);
  endtask

  task automatic test_repeat_random();
    int nsel;
    int hold;
    for (int it = 0; it < 6; it++) begin
      nsel = int'($urandom_range(0, 6));
      for (int j = 0; j < nsel; j++) begin
        press(1'b0, 6);
        sel_m = (sel_m + 1) % 7;
      end
      clear_pulses();
      hold = 4 * int'($urandom_range(1, 11)) + 3;
      press(1'b1, hold);
      check_repeat("repeat_rand", hold);
    end
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick1Hz = 1'b1;
    @(negedge clk);
    tick1Hz = 1'b0;
  endtask

  task automatic test_timeout();
    goto_field(5);
    for (int t = 1; t <= int'(TT); t++) begin
      pulse_tick();
      if (t < int'(TT)) begin
        if (selected !== 4'd5) begin
          failures++; $display("FAIL timeout_early%0d: got %0d want 5", t, selected);
        end
        checks++;
        repeat (5) @(negedge clk);
      end
    end
    sel_m = 0;
    if (selected !== 4'd0) begin
      failures++; $display("FAIL timeout_exit: got %0d want 0", selected);
    end
    checks++;
    if (blankMask !== 6'd0) begin
      failures++; $display("FAIL timeout_blank: got %b want 000000", blankMask);
    end
    checks++;
    // An advance press restarts the idle count.
    goto_field(1);
    pulse_tick();
    pulse_tick();
    press(1'b1, 6);
    pulse_tick();
    pulse_tick();
    if (selected !== 4'd1) begin
      failures++; $display("FAIL timeout_restart: got %0d want 1", selected);
    end
    checks++;
    pulse_tick();
    sel_m = 0;
    if (selected !== 4'd0) begin
      failures++; $display("FAIL timeout_after_restart: got %0d want 0", selected);
    end
    checks++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_blink_and_coincide();
    int found;
    logic [5:0] want;
    goto_field(1);
    found = -1;
    @(negedge clk);
    selectKey = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 8) selectKey = 1'b1;
      if (found < 0 && selected == 4'd2) found = k;
      if (found >= 0 && (k - found) < 32) begin
        want = ((((k - found) / int'(BH)) % 2) == 1) ? 6'b000010 : 6'b000000;
        if (blankMask !== want) begin
          failures++; $display("FAIL blink_k%0d: got %b want %b", k - found, blankMask, want);
        end
        checks++;
      end
    end
    if (found < 0) begin
      failures++; $display("FAIL blink_enter: selected %0d never reached 2", selected);
    end
    checks++;
    sel_m = 2;
    clear_pulses();
    @(negedge clk);
    selectKey = 1'b0;
    advanceKey = 1'b0;
    repeat (8) @(negedge clk);
    selectKey = 1'b1;
    advanceKey = 1'b1;
    repeat (14) @(negedge clk);
    sel_m = 3;
    if (selected !== 4'd3) begin
      failures++; $display("FAIL coincide_sel: got %0d want 3", selected);
    end
    checks++;
    if (pulse_cyc.size() != 0) begin
      failures++; $display("FAIL coincide_inc: got %0d pulses want 0", pulse_cyc.size());
    end
    checks++;
  endtask

  task automatic test_reset_mid_repeat();
    goto_field(4);
    clear_pulses();
    @(negedge clk);
    advanceKey = 1'b0;
    repeat (20) @(negedge clk);
    if (pulse_cyc.size() < 1) begin
      failures++; $display("FAIL midrep_started: got %0d pulses want >=1", pulse_cyc.size());
    end
    checks++;
    nReset = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    sel_m = 0;
    if (selected !== 4'd0) begin
      failures++; $display("FAIL midrep_sel: got %0d want 0", selected);
    end
    checks++;
    if (incPulse !== 6'd0) begin
      failures++; $display("FAIL midrep_inc: got %b want 000000", incPulse);
    end
    checks++;
    clear_pulses();
    repeat (10) @(negedge clk);
    press(1'b0, 6);
    sel_m = 1;
    if (selected !== 4'd1) begin
      failures++; $display("FAIL midrep_reselect: got %0d want 1", selected);
    end
    checks++;
    repeat (30) @(negedge clk);
    advanceKey = 1'b1;
    repeat (14) @(negedge clk);
    if (pulse_cyc.size() != 0) begin
      failures++; $display("FAIL midrep_held: got %0d pulses want 0", pulse_cyc.size());
    end
    checks++;
    press(1'b1, 6);
    if (pulse_cyc.size() != 1) begin
      failures++; $display("FAIL midrep_repress: got %0d pulses want 1", pulse_cyc.size());
    end
    checks++;
    if (pulse_val.size() > 0) begin
      if (pulse_val[0] !== 6'b000001) begin
        failures++; $display("FAIL midrep_val: got %b want 000001", pulse_val[0]);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_select_cycle();
    test_debounce();
    test_auto_repeat();
    test_repeat_random();
    test_timeout();
    test_blink_and_coincide();
    test_reset_mid_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
